// File: rtl/grid_mem_responder.sv
// grid_mem_responder
//   Owns the playfield grid RAM (DEPTH x 8-bit cells, row-major). The RAM is
//   shared by three users:
//     - the line clearer: combinational read, synchronous write;
//     - the piece placer: a req/gnt port with registered read data;
//     - the display: a free-running combinational read port.
//   After reset, and again on every new_game pulse, the grid is swept to 0.
//   The sweep writes one cell per cycle.
//
// Ports
//   clk, rst            rising-edge clock, async active-low reset
//   new_game, init_busy start a wipe / wipe in progress
//   c_active, c_addr, c_we, c_wdata, c_rdata   line-clearer port
//   p_req, p_addr, p_we, p_wdata, p_gnt, p_rdata piece-placer port
//   v_addr, v_rdata                             display read port
module grid_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int ROW_STRIDE = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    output logic       init_busy,
    input  logic       c_active,
    input  logic [7:0] c_addr,
    input  logic       c_we,
    input  logic [7:0] c_wdata,
    output logic [7:0] c_rdata,
    input  logic       p_req,
    input  logic [7:0] p_addr,
    input  logic       p_we,
    input  logic [7:0] p_wdata,
    output logic       p_gnt,
    output logic [7:0] p_rdata,
    input  logic [7:0] v_addr,
    output logic [7:0] v_rdata
);

    // ROW_STRIDE only describes the layout for the users of the grid.
    if (DEPTH < 1 || DEPTH > 256 || ROW_STRIDE < 1) begin : g_bad_param
        $error("grid_mem_responder: DEPTH must be 1..256, ROW_STRIDE >= 1");
    end

    localparam logic [7:0] LAST = 8'(DEPTH - 1);

    typedef enum logic {INIT, SERVE} state_t;

    state_t     r_state, w_next_state;
    logic [7:0] r_ptr, w_next_ptr;
    logic       r_p_gnt;
    logic [7:0] r_p_rdata;
    logic [7:0] r_mem [DEPTH];

    logic       w_we;
    logic [7:0] w_waddr;
    logic [7:0] w_wdata;
    logic       w_p_acc;
    logic       w_c_ok, w_p_ok, w_v_ok;
    logic [7:0] w_p_rd;

    // Addresses beyond the array are never written and read back as 0.
    // With a full 256-cell grid every 8-bit address is in range.
    if (DEPTH >= 256) begin : g_full
        assign w_c_ok = 1'b1;
        assign w_p_ok = 1'b1;
        assign w_v_ok = 1'b1;
    end else begin : g_part
        assign w_c_ok = (c_addr < 8'(DEPTH));
        assign w_p_ok = (p_addr < 8'(DEPTH));
        assign w_v_ok = (v_addr < 8'(DEPTH));
    end

    // Zero-latency reads: the clearer samples data in the same cycle it
    // presents the address, so these must stay combinational.
    assign c_rdata = w_c_ok ? r_mem[c_addr] : 8'h00;
    assign v_rdata = w_v_ok ? r_mem[v_addr] : 8'h00;
    assign w_p_rd  = w_p_ok ? r_mem[p_addr] : 8'h00;

    assign init_busy = (r_state == INIT);
    assign p_gnt     = r_p_gnt;
    assign p_rdata   = r_p_rdata;

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_we         = 1'b0;
        w_waddr      = r_ptr;
        w_wdata      = 8'h00;
        w_p_acc      = 1'b0;
        case (r_state)
            INIT: begin
                // Clear one cell per cycle. A new_game here restarts the sweep;
                // writing 0 to the current cell on that edge is harmless.
                w_we = 1'b1;
                if (new_game) begin
                    w_next_ptr = 8'h00;
                end else if (r_ptr == LAST) begin
                    w_next_ptr   = 8'h00;
                    w_next_state = SERVE;
                end else begin
                    w_next_ptr = r_ptr + 8'd1;
                end
            end
            SERVE: begin
                // new_game overrides any traffic in the same cycle.
                // The clearer has priority over the placer.
                if (new_game) begin
                    w_next_state = INIT;
                    w_next_ptr   = 8'h00;
                end else if (c_active) begin
                    if (c_we && w_c_ok) begin
                        w_we    = 1'b1;
                        w_waddr = c_addr;
                        w_wdata = c_wdata;
                    end
                end else if (p_req) begin
                    w_p_acc = 1'b1;
                    if (p_we && w_p_ok) begin
                        w_we    = 1'b1;
                        w_waddr = p_addr;
                        w_wdata = p_wdata;
                    end
                end
            end
            default: begin
                w_next_state = INIT;
                w_next_ptr   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= INIT;
            r_ptr     <= 8'h00;
            r_p_gnt   <= 1'b0;
            r_p_rdata <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_p_gnt <= w_p_acc;
            // Read data sees the pre-edge contents and holds until the next
            // accepted read.
            if (w_p_acc && !p_we) begin
                r_p_rdata <= w_p_rd;
            end
        end
    end

    // RAM array has no reset; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_grid_mem_responder.sv
module tb_grid_mem_responder;

    logic       clk;
    logic       rst;
    logic       new_game;
    logic       init_busy;
    logic       c_active;
    logic [7:0] c_addr;
    logic       c_we;
    logic [7:0] c_wdata;
    logic [7:0] c_rdata;
    logic       p_req;
    logic [7:0] p_addr;
    logic       p_we;
    logic [7:0] p_wdata;
    logic       p_gnt;
    logic [7:0] p_rdata;
    logic [7:0] v_addr;
    logic [7:0] v_rdata;

    int n_tot = 0;
    int n_bad = 0;

    grid_mem_responder #(.DEPTH(256), .ROW_STRIDE(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .new_game (new_game),
        .init_busy(init_busy),
        .c_active (c_active),
        .c_addr   (c_addr),
        .c_we     (c_we),
        .c_wdata  (c_wdata),
        .c_rdata  (c_rdata),
        .p_req    (p_req),
        .p_addr   (p_addr),
        .p_we     (p_we),
        .p_wdata  (p_wdata),
        .p_gnt    (p_gnt),
        .p_rdata  (p_rdata),
        .v_addr   (v_addr),
        .v_rdata  (v_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until init_busy drops (bounded).
    task automatic wait_init(output int n, output int gnts);
        n = 0;
        gnts = 0;
        while (init_busy && n < 1000) begin
            tick();
            n++;
            if (p_gnt && init_busy) gnts++;
        end
    endtask

    task automatic vread(input logic [7:0] a, input logic [7:0] exp, input string tag);
        v_addr = a;
        #1;
        chk(tag, v_rdata, exp);
    endtask

    int n, g, bad_cells;

    initial begin
        rst = 1'b1; new_game = 0;
        c_active = 0; c_addr = 0; c_we = 0; c_wdata = 0;
        p_req = 0; p_addr = 0; p_we = 0; p_wdata = 0; v_addr = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", init_busy, 1);
        chk("rst_gnt", p_gnt, 0);
        chk("rst_rdata", p_rdata, 0);
        tick(); tick();
        chk("rst_held_busy", init_busy, 1);

        // Release reset with a read request already pending.
        rst = 1'b1;
        p_req = 1; p_we = 0; p_addr = 8'd0;
        wait_init(n, g);
        chk("init_len", n, 256);
        chk("init_no_gnt", g, 0);
        chk("gnt_after_init_edge", p_gnt, 0);
        tick();
        chk("first_gnt", p_gnt, 1);
        chk("first_rdata", p_rdata, 0);
        p_req = 0;
        tick();
        chk("gnt_drop", p_gnt, 0);

        bad_cells = 0;
        for (int a = 0; a < 256; a++) begin
            v_addr = 8'(a);
            #1;
            if (v_rdata !== 8'h00) bad_cells++;
        end
        chk("swept_zero", bad_cells, 0);

        // Placer write, then back-to-back read of the same cell.
        p_req = 1; p_we = 1; p_addr = 8'd13; p_wdata = 8'h5A;
        tick();
        chk("pw_gnt", p_gnt, 1);
        vread(8'd13, 8'h5A, "pw_mem13");
        p_we = 0;
        tick();
        chk("pr_gnt", p_gnt, 1);
        chk("pr_rdata", p_rdata, 8'h5A);
        p_req = 0;
        tick();
        chk("pr_gnt_drop", p_gnt, 0);
        chk("pr_rdata_hold", p_rdata, 8'h5A);

        // Clearer beats placer at the same address.
        c_active = 1; c_we = 1; c_addr = 8'd25; c_wdata = 8'h03;
        p_req = 1; p_we = 1; p_addr = 8'd25; p_wdata = 8'h07;
        tick();
        chk("prio_no_gnt", p_gnt, 0);
        vread(8'd25, 8'h03, "prio_mem25_c");
        c_active = 0;
        tick();
        chk("prio_gnt", p_gnt, 1);
        vread(8'd25, 8'h07, "prio_mem25_p");
        p_req = 0; c_we = 0;
        tick();
        chk("prio_gnt_drop", p_gnt, 0);

        // Same-cycle read/write collision on the clearer port.
        c_active = 1; c_we = 1; c_addr = 8'd1; c_wdata = 8'h11;
        tick();
        c_we = 0;
        #1;
        chk("coll_read", c_rdata, 8'h11);
        c_we = 1; c_wdata = 8'h22;
        #1;
        chk("coll_old", c_rdata, 8'h11);
        vread(8'd1, 8'h11, "coll_old_v");
        tick();
        chk("coll_new", c_rdata, 8'h22);
        c_we = 0; c_active = 0;

        // c_we without c_active is ignored.
        c_we = 1; c_addr = 8'd2; c_wdata = 8'hFF;
        tick();
        c_we = 0;
        vread(8'd2, 8'h00, "cwe_ignored");

        // Fill cells 1..10, then new_game with a placer write pending.
        c_active = 1; c_we = 1;
        for (int a = 1; a <= 10; a++) begin
            c_addr = 8'(a); c_wdata = 8'(8'h40 + a);
            tick();
        end
        c_we = 0; c_active = 0;
        vread(8'd5, 8'h45, "fill_mem5");
        new_game = 1;
        p_req = 1; p_we = 1; p_addr = 8'd3; p_wdata = 8'h99;
        tick();
        new_game = 0;
        chk("ng_busy", init_busy, 1);
        chk("ng_no_gnt", p_gnt, 0);
        wait_init(n, g);
        chk("ng_len", n, 256);
        chk("ng_no_gnt_init", g, 0);
        bad_cells = 0;
        for (int a = 1; a <= 10; a++) begin
            v_addr = 8'(a);
            #1;
            if (v_rdata !== 8'h00) bad_cells++;
        end
        chk("ng_wiped", bad_cells, 0);
        vread(8'd13, 8'h00, "ng_wiped13");
        tick();
        chk("ng_held_gnt", p_gnt, 1);
        vread(8'd3, 8'h99, "ng_held_write");

        // Async reset in SERVE with a grant and read data outstanding.
        p_we = 0;
        tick();
        chk("pre_rst_rdata", p_rdata, 8'h99);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", init_busy, 1);
        chk("arst_gnt", p_gnt, 0);
        chk("arst_rdata", p_rdata, 0);
        p_req = 0;
        tick();
        rst = 1'b1;
        wait_init(n, g);
        chk("arst_len", n, 256);

        // Async reset in the middle of a sweep restarts it from 0.
        new_game = 1;
        tick();
        new_game = 0;
        repeat (100) tick();
        chk("mid_busy", init_busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_arst_busy", init_busy, 1);
        chk("mid_arst_gnt", p_gnt, 0);
        tick();
        rst = 1'b1;
        wait_init(n, g);
        chk("mid_arst_len", n, 256);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_mem_responder.md
Name: grid_mem_responder

Overview:
- Owns the playfield grid RAM: DEPTH x 8-bit cells, row-major, ROW_STRIDE cells per row, first playable row based at address 1.
- Serves the grid bus driven by the line clearer: combinational read, synchronous write.
- Also serves a req/gnt port for the piece placer and a free-running read port for the display.
- Sweeps the grid to air (0) after reset and on new_game.

Parameters:
DEPTH, 256, number of grid cells; address width is 8, so DEPTH must be 256 or less.
ROW_STRIDE, 12, address distance between vertically adjacent cells; informational only, no internal use.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
new_game  in  1  single-cycle pulse; starts a grid wipe.
init_busy  out  1  high while the wipe is in progress.
c_active  in  1  line-clearer owns the grid (tie to the clearer's en).
c_addr  in  8  line-clearer address.
c_we  in  1  line-clearer write enable.
c_wdata  in  8  line-clearer write data.
c_rdata  out  8  line-clearer read data, combinational.
p_req  in  1  piece-placer request.
p_addr  in  8  piece-placer address.
p_we  in  1  piece-placer write (1) or read (0).
p_wdata  in  8  piece-placer write data.
p_gnt  out  1  registered acknowledge, one pulse per accepted request.
p_rdata  out  8  registered read data, valid while p_gnt=1.
v_addr  in  8  display read address.
v_rdata  out  8  display read data, combinational.

Behaviour:
- Reset (rst=0, async):
  - State = INIT, wipe pointer = 0.
  - p_gnt=0, p_rdata=0, init_busy=1.
  - RAM contents are not reset directly; the INIT sweep clears them.
- States: INIT, SERVE.
- INIT:
  - Each cycle writes 0 to mem[ptr], then ptr+1.
  - On the edge that writes ptr=DEPTH-1: go to SERVE, init_busy falls.
  - Sweep length after reset release is exactly DEPTH cycles.
  - All c_we and p_req are ignored; p_gnt stays 0.
- SERVE, priority c_active > p_req:
  - If c_active=1 and c_we=1: mem[c_addr] <= c_wdata at the edge.
  - If c_active=0 and p_req=1: request accepted at the edge.
    - p_we=1: mem[p_addr] <= p_wdata.
    - p_we=0: p_rdata <= mem[p_addr] (pre-edge contents).
    - p_gnt=1 during the following cycle.
  - Back-to-back: p_req held high is accepted every cycle; p_gnt stays high.
  - p_req while c_active=1: not accepted, p_gnt=0. Placer must hold req/addr/we/wdata until it sees p_gnt.
  - p_rdata holds its last value when p_gnt=0; it changes only on an accepted read.
  - c_we with c_active=0 is ignored.
- new_game in SERVE: next state INIT, ptr=0. It wins over any same-cycle c_we or p_req (neither is performed, no p_gnt).
- new_game during INIT: restart the sweep, ptr=0.
- Read ports:
  - c_rdata = mem[c_addr] and v_rdata = mem[v_addr], zero latency, in all states.
  - The clearer samples data_in in the same cycle it presents addr; a registered read is forbidden.
  - Read of an address being written in the same cycle returns the old contents; the new value is visible the cycle after the edge.
- Address range: addresses >= DEPTH are not written; they read as 0.

Test Plan:
- Reset deassert -> init_busy=1 for exactly 256 cycles. Then v_rdata=0 for every v_addr 0..255. A p_req issued during INIT gets its first p_gnt only after init_busy=0.
- Placer write then read:
  - p_req=1, p_we=1, p_addr=13, p_wdata=8'h5A -> p_gnt pulse next cycle, v_rdata(13)=8'h5A.
  - p_we=0, p_addr=13 -> p_gnt=1 with p_rdata=8'h5A.
- Clearer priority: c_active=1, c_we=1, c_addr=25, c_wdata=8'h03 while p_req=1, p_addr=25, p_wdata=8'h07 -> no p_gnt and mem[25]=8'h03. Drop c_active -> p_gnt next cycle, mem[25]=8'h07.
- Combinational read / write collision:
  - mem[1]=8'h11, c_active=1, c_addr=1 -> c_rdata=8'h11 in the same cycle.
  - c_we=1, c_wdata=8'h22 -> c_rdata reads 8'h11 until the edge, 8'h22 after.
- new_game mid-traffic: fill cells 1..10 nonzero, pulse new_game with p_req=1 -> no p_gnt, init_busy=1 for 256 cycles, cells 1..10 read 0 afterwards.
- Async reset mid-INIT at ptr~100: drive rst=0 between edges -> init_busy=1 and p_gnt=0 immediately; the sweep restarts from 0 and runs a full 256 cycles.
